// File: rtl/isp_frame_sequencer.sv
// Frame-level scheduler: validates a start command, launches Gaussian blur then FAST, reports status.
// Optional per-stage watchdog is compiled in when SEQ_WATCHDOG_EN is defined.
module isp_frame_sequencer #(
    parameter int unsigned X_MAX       = 200,
    parameter int unsigned Y_MAX       = 200,
    parameter int unsigned MAX_KERNEL  = 3,
    parameter int unsigned WDOG_CYCLES = 2**20
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [$clog2(X_MAX)-1:0]      cfg_max_x,
    input  logic [$clog2(Y_MAX)-1:0]      cfg_max_y,
    input  logic [2:0]                    cfg_sigma,
    input  logic [$clog2(MAX_KERNEL)-1:0] cfg_kernel_size,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code,
    output logic [15:0]                   frame_count,
    output logic                          blur_new_trans,
    output logic [$clog2(X_MAX)-1:0]      blur_max_x,
    output logic [$clog2(Y_MAX)-1:0]      blur_max_y,
    output logic [2:0]                    blur_sigma,
    output logic [$clog2(MAX_KERNEL)-1:0] blur_kernel_size,
    input  logic                          blur_conv_done,
    output logic                          fast_start,
    input  logic                          fast_done
);

    localparam int unsigned XW = $clog2(X_MAX);
    localparam int unsigned YW = $clog2(Y_MAX);
    localparam int unsigned KW = $clog2(MAX_KERNEL);

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrBadCfg  = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;
    localparam logic [1:0] ErrAbort   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLaunchBlur,
        StWaitBlur,
        StLaunchFast,
        StWaitFast,
        StDone,
        StError
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [1:0]      r_err_code;
    logic [1:0]      w_err_code_next;
    logic            w_latch_cfg;
    logic            w_cfg_valid;
    logic            w_wdog_expired;
    logic [15:0]     r_frame_count;
    logic [XW-1:0]   r_blur_max_x;
    logic [YW-1:0]   r_blur_max_y;
    logic [2:0]      r_blur_sigma;
    logic [KW-1:0]   r_blur_kernel_size;

    assign w_cfg_valid = (cfg_max_x != '0) && (cfg_max_y != '0) && (cfg_sigma != 3'd0) &&
                         cfg_kernel_size[0] && (32'(cfg_kernel_size) <= MAX_KERNEL);

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned WdogW = $clog2(WDOG_CYCLES);

    logic [WdogW-1:0] r_wdog;
    logic             w_in_wait;

    assign w_in_wait = (r_state == StWaitBlur) || (r_state == StWaitFast);

    // Launch states are the only way into a wait state, so clearing there covers every entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wdog <= '0;
        end else if ((r_state == StLaunchBlur) || (r_state == StLaunchFast)) begin
            r_wdog <= '0;
        end else if (w_in_wait) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_wdog_expired = w_in_wait && (r_wdog == WdogW'(WDOG_CYCLES - 1));
`else
    assign w_wdog_expired = 1'b0;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_err_code_next = r_err_code;
        w_latch_cfg     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    if (w_cfg_valid) begin
                        w_state_next    = StLaunchBlur;
                        w_err_code_next = ErrNone;
                        w_latch_cfg     = 1'b1;
                    end else begin
                        w_state_next    = StError;
                        w_err_code_next = ErrBadCfg;
                    end
                end
            end
            StLaunchBlur: w_state_next = StWaitBlur;
            StWaitBlur: begin
                if (blur_conv_done) begin
                    w_state_next = StLaunchFast;
                end else if (w_wdog_expired) begin
                    w_state_next    = StError;
                    w_err_code_next = ErrTimeout;
                end
            end
            StLaunchFast: w_state_next = StWaitFast;
            StWaitFast: begin
                if (fast_done) begin
                    w_state_next = StDone;
                end else if (w_wdog_expired) begin
                    w_state_next    = StError;
                    w_err_code_next = ErrTimeout;
                end
            end
            StDone:  w_state_next = StIdle;
            StError: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase

        // Abort overrides any stage completion seen in the same cycle.
        if (abort && (r_state != StIdle) && (r_state != StError)) begin
            w_state_next    = StError;
            w_err_code_next = ErrAbort;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= StIdle;
            r_err_code <= ErrNone;
        end else begin
            r_state    <= w_state_next;
            r_err_code <= w_err_code_next;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_blur_max_x       <= '0;
            r_blur_max_y       <= '0;
            r_blur_sigma       <= '0;
            r_blur_kernel_size <= '0;
        end else if (w_latch_cfg) begin
            r_blur_max_x       <= cfg_max_x;
            r_blur_max_y       <= cfg_max_y;
            r_blur_sigma       <= cfg_sigma;
            r_blur_kernel_size <= cfg_kernel_size;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_frame_count <= '0;
        end else if (r_state == StDone) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign busy             = (r_state != StIdle);
    assign done             = (r_state == StDone);
    assign err              = (r_state == StError);
    assign err_code         = r_err_code;
    assign frame_count      = r_frame_count;
    assign blur_new_trans   = (r_state == StLaunchBlur);
    assign fast_start       = (r_state == StLaunchFast);
    assign blur_max_x       = r_blur_max_x;
    assign blur_max_y       = r_blur_max_y;
    assign blur_sigma       = r_blur_sigma;
    assign blur_kernel_size = r_blur_kernel_size;

endmodule

// File: tb/tb_isp_frame_sequencer.sv
// Directed bench for isp_frame_sequencer; done/err events are scoreboarded against a queue.
module tb_isp_frame_sequencer;

    localparam int unsigned X_MAX      = 200;
    localparam int unsigned Y_MAX      = 200;
    localparam int unsigned MAX_KERNEL = 3;
    localparam int unsigned WDOG       = 16;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_max_x = '0;
    logic [7:0] cfg_max_y = '0;
    logic [2:0] cfg_sigma = '0;
    logic [1:0] cfg_kernel_size = '0;
    logic       blur_conv_done = 1'b0;
    logic       fast_done = 1'b0;

    logic        busy, done, err, blur_new_trans, fast_start;
    logic [1:0]  err_code;
    logic [15:0] frame_count;
    logic [7:0]  blur_max_x, blur_max_y;
    logic [2:0]  blur_sigma;
    logic [1:0]  blur_kernel_size;

    isp_frame_sequencer #(
        .X_MAX      (X_MAX),
        .Y_MAX      (Y_MAX),
        .MAX_KERNEL (MAX_KERNEL),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .start           (start),
        .abort           (abort),
        .cfg_max_x       (cfg_max_x),
        .cfg_max_y       (cfg_max_y),
        .cfg_sigma       (cfg_sigma),
        .cfg_kernel_size (cfg_kernel_size),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .err_code        (err_code),
        .frame_count     (frame_count),
        .blur_new_trans  (blur_new_trans),
        .blur_max_x      (blur_max_x),
        .blur_max_y      (blur_max_y),
        .blur_sigma      (blur_sigma),
        .blur_kernel_size(blur_kernel_size),
        .blur_conv_done  (blur_conv_done),
        .fast_start      (fast_start),
        .fast_done       (fast_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  n_blur   = 0;
    int  n_fast   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] x, input logic [7:0] y, input logic [2:0] s,
                           input logic [1:0] k);
        cfg_max_x       = x;
        cfg_max_y       = y;
        cfg_sigma       = s;
        cfg_kernel_size = k;
    endtask

    task automatic check_blur(input string tag, input logic [7:0] x, input logic [7:0] y,
                              input logic [2:0] s, input logic [1:0] k);
        check({tag, "_x"}, 32'(blur_max_x), 32'(x));
        check({tag, "_y"}, 32'(blur_max_y), 32'(y));
        check({tag, "_sigma"}, 32'(blur_sigma), 32'(s));
        check({tag, "_kernel"}, 32'(blur_kernel_size), 32'(k));
    endtask

    // Outputs are sampled mid-cycle; every done/err pulse must match the next queued event.
    always @(negedge clk) begin
        if (blur_new_trans) n_blur++;
        if (fast_start) n_fast++;
        if (done || err) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL ev_unexpected observed done=%0b err=%0b expected none", done, err);
            end
            if (exp_q.size() > 0) begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_kind_err", 32'(err), 32'(e.is_err));
                check("ev_kind_done", 32'(done), 32'(!e.is_err));
                check("ev_code", 32'(err_code), 32'(e.code));
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_code", 32'(err_code), 0);
        check("rst_fc", 32'(frame_count), 0);
        check("rst_blur_trans", 32'(blur_new_trans), 0);
        check("rst_fast_start", 32'(fast_start), 0);
        check_blur("rst_blur", 8'd0, 8'd0, 3'd0, 2'd0);
        n_rst = 1'b1;
        tick();

        // Nominal frame with delayed stage completions
        set_cfg(8'd9, 8'd9, 3'd1, 2'd3);
        start = 1'b1;
        exp_q.push_back('{is_err: 1'b0, code: 2'd0});
        tick();
        start = 1'b0;
        check("f1_blur_trans_t1", 32'(blur_new_trans), 1);
        check("f1_busy", 32'(busy), 1);
        set_cfg(8'd1, 8'd2, 3'd5, 2'd1);
        tick();
        check("f1_blur_trans_t2", 32'(blur_new_trans), 0);
        repeat (18) tick();
        blur_conv_done = 1'b1;
        tick();
        blur_conv_done = 1'b0;
        check("f1_fast_start", 32'(fast_start), 1);
        tick();
        check("f1_fast_start_off", 32'(fast_start), 0);
        repeat (3) tick();
        fast_done = 1'b1;
        tick();
        fast_done = 1'b0;
        check("f1_done", 32'(done), 1);
        check("f1_fc_pre", 32'(frame_count), 0);
        check("f1_busy_done", 32'(busy), 1);
        tick();
        check("f1_done_off", 32'(done), 0);
        check("f1_fc", 32'(frame_count), 1);
        check("f1_busy_off", 32'(busy), 0);
        check("f1_code", 32'(err_code), 0);
        check_blur("f1_blur", 8'd9, 8'd9, 3'd1, 2'd3);
        tick();
        check("f1_n_blur", 32'(n_blur), 1);
        check("f1_n_fast", 32'(n_fast), 1);

        // Invalid configs: even kernel, then zero sigma
        set_cfg(8'd5, 8'd5, 3'd1, 2'd2);
        start = 1'b1;
        exp_q.push_back('{is_err: 1'b1, code: 2'd1});
        tick();
        start = 1'b0;
        check("bad_k_err", 32'(err), 1);
        check("bad_k_busy", 32'(busy), 1);
        check("bad_k_code", 32'(err_code), 1);
        tick();
        check("bad_k_busy_off", 32'(busy), 0);
        check("bad_k_code_hold", 32'(err_code), 1);
        set_cfg(8'd5, 8'd5, 3'd0, 2'd3);
        start = 1'b1;
        exp_q.push_back('{is_err: 1'b1, code: 2'd1});
        tick();
        start = 1'b0;
        check("bad_s_err", 32'(err), 1);
        check("bad_s_code", 32'(err_code), 1);
        tick();
        check("bad_s_busy_off", 32'(busy), 0);
        check_blur("bad_blur", 8'd9, 8'd9, 3'd1, 2'd3);
        check("bad_n_blur", 32'(n_blur), 1);

        // Abort coincident with blur completion
        set_cfg(8'd7, 8'd8, 3'd2, 2'd1);
        start = 1'b1;
        exp_q.push_back('{is_err: 1'b1, code: 2'd3});
        tick();
        start = 1'b0;
        check("ab_code_clear", 32'(err_code), 0);
        tick();
        repeat (3) tick();
        abort = 1'b1;
        blur_conv_done = 1'b1;
        tick();
        abort = 1'b0;
        blur_conv_done = 1'b0;
        check("ab_err", 32'(err), 1);
        check("ab_code", 32'(err_code), 3);
        check("ab_fast_start", 32'(fast_start), 0);
        tick();
        check("ab_busy_off", 32'(busy), 0);
        repeat (2) tick();
        check("ab_n_fast", 32'(n_fast), 1);
        check_blur("ab_blur", 8'd7, 8'd8, 3'd2, 2'd1);

        // Start and stray blur done during WAIT_FAST are ignored
        set_cfg(8'd9, 8'd9, 3'd1, 2'd3);
        start = 1'b1;
        exp_q.push_back('{is_err: 1'b0, code: 2'd0});
        tick();
        start = 1'b0;
        tick();
        blur_conv_done = 1'b1;
        tick();
        blur_conv_done = 1'b0;
        tick();
        set_cfg(8'd3, 8'd3, 3'd3, 2'd1);
        start = 1'b1;
        blur_conv_done = 1'b1;
        tick();
        start = 1'b0;
        blur_conv_done = 1'b0;
        check("ig_blur_trans", 32'(blur_new_trans), 0);
        check("ig_fast_start", 32'(fast_start), 0);
        fast_done = 1'b1;
        tick();
        fast_done = 1'b0;
        check("ig_done", 32'(done), 1);
        tick();
        check("ig_fc", 32'(frame_count), 2);
        check_blur("ig_blur", 8'd9, 8'd9, 3'd1, 2'd3);
        tick();
        check("ig_n_blur", 32'(n_blur), 3);
        check("ig_n_fast", 32'(n_fast), 2);

        // Reset asserted during WAIT_FAST
        set_cfg(8'd4, 8'd6, 3'd2, 2'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        blur_conv_done = 1'b1;
        tick();
        blur_conv_done = 1'b0;
        tick();
        check("mr_busy_pre", 32'(busy), 1);
        n_rst = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 0);
        check("mr_fc", 32'(frame_count), 0);
        check("mr_code", 32'(err_code), 0);
        check("mr_fast_start", 32'(fast_start), 0);
        check_blur("mr_blur", 8'd0, 8'd0, 3'd0, 2'd0);
        fast_done = 1'b1;
        tick();
        fast_done = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        check("mr_idle", 32'(busy), 0);
        check("mr_n_fast", 32'(n_fast), 3);

        // Stage that never completes
        set_cfg(8'd9, 8'd9, 3'd1, 2'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
`ifdef SEQ_WATCHDOG_EN
        exp_q.push_back('{is_err: 1'b1, code: 2'd2});
        repeat (WDOG - 1) tick();
        check("wd_not_yet", 32'(err), 0);
        check("wd_busy", 32'(busy), 1);
        tick();
        check("wd_err", 32'(err), 1);
        check("wd_code", 32'(err_code), 2);
        tick();
`else
        repeat (40) tick();
        check("nowd_busy", 32'(busy), 1);
        check("nowd_err", 32'(err), 0);
        abort = 1'b1;
        exp_q.push_back('{is_err: 1'b1, code: 2'd3});
        tick();
        abort = 1'b0;
        check("nowd_abort_code", 32'(err_code), 3);
        tick();
`endif
        check("stall_idle", 32'(busy), 0);

        // frame_count wrap from 0xFFFF on a minimum-length frame
        force dut.r_frame_count = 16'hFFFF;
        #1;
        release dut.r_frame_count;
        #1;
        check("wrap_pre", 32'(frame_count), 32'h0000_FFFF);
        start = 1'b1;
        exp_q.push_back('{is_err: 1'b0, code: 2'd0});
        tick();
        start = 1'b0;
        tick();
        blur_conv_done = 1'b1;
        tick();
        blur_conv_done = 1'b0;
        tick();
        fast_done = 1'b1;
        tick();
        fast_done = 1'b0;
        check("wrap_done", 32'(done), 1);
        tick();
        check("wrap_fc", 32'(frame_count), 0);
        check("wrap_busy", 32'(busy), 0);
        tick();

        check("q_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
